mask_gen_param: RTL and testbench
=================================

Name: mask_gen_param

Overview:
Parametrised multi-cycle mask generator for the connected-domain filter datapath.
- Builds a MASK_W-bit run mask from latched bound indices, one binary weight per cycle, MSB weight first.
- Modes: left fill, right fill, window, inverted window.
- Result is presented under a level handshake. Replaces the fixed 512-bit left/right-only generator in filter row processing.

Parameters:
MASK_W, 512, mask width in bits; power of 2, minimum 4
IDX_W, $clog2(MASK_W), bound index width; derived, not overridden

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_start  in  1  level request; sampled only in IDLE
i_mode  in  2  00 left fill, 01 right fill, 10 window, 11 inverted window
i_bound_a  in  IDX_W  fill count (modes 00/01); window low bit lo (modes 10/11)
i_bound_b  in  IDX_W  window high bit hi (modes 10/11); ignored in 00/01
o_busy  out  1  high in BUILD_A, BUILD_B, COMBINE
o_done  out  1  high only in DONE
o_err  out  1  lo>hi in a window mode; valid only while o_done, else 0
o_mask  out  MASK_W  result while o_done; all-zero otherwise

Behaviour:
- Reset (async, any state, including mid-build):
  - state IDLE; all internal registers 0.
  - o_busy, o_done, o_err = 0; o_mask = 0.
- States: IDLE, BUILD_A, BUILD_B, COMBINE, DONE.
- IDLE, i_start=1 at edge E0:
  - latch i_mode, i_bound_a, i_bound_b; clear accumulator; step counter = IDX_W-1; go BUILD_A.
  - latched err flag = (mode[1] && bound_a > bound_b).
  - Inputs are not sampled again until the next IDLE.
- BUILD_A, one edge per step s = IDX_W-1 down to 0. If bit s of the latched bound_a is 1, shift 2^s ones into the accumulator:
  - left mode: ones enter at the MSB side; contents shift toward the LSB.
  - right and window modes: ones enter at the LSB side; contents shift toward the MSB.
  - Bits are taken from the latched copy, never from live inputs.
- Fill semantics: left N → bits [MASK_W-1 : MASK_W-N] set; right N → bits [N-1:0] set; N=0 → all zero; max N = MASK_W-1.
- End of BUILD_A, at s=0:
  - modes 00/01: go DONE. o_done rises IDX_W cycles after E0.
  - window modes: copy accumulator to regA (right fill of lo); clear accumulator; reset counter; go BUILD_B.
- BUILD_B: same right-fill steps using latched bound_b. At s=0 go COMBINE.
- COMBINE, one edge:
  - win = ((accB << 1) | 1) & ~regA, which sets bits lo..hi inclusive.
  - result = win in mode 10, ~win in mode 11.
  - If err: win = 0, so result is all-zero in mode 10 and all-ones in mode 11.
  - Go DONE. o_done rises 2*IDX_W+1 cycles after E0.
- DONE:
  - o_mask and o_err held stable.
  - Stay while i_start=1; on i_start=0 go IDLE next edge, after which o_mask reads 0.
  - Back-to-back requests need at least one low cycle of i_start.
- Modes 00/01 force o_err = 0.
- Illegal state encoding → IDLE, registers cleared.

Decomposition:
- Package mask_gen_pkg:
  - mode localparams MODE_LEFT=2'b00, MODE_RIGHT=2'b01, MODE_WIN=2'b10, MODE_NWIN=2'b11.
  - state enum/encoding.
- One sub-module, mask_fill_engine (params MASK_W, IDX_W):
  - holds the accumulator and step counter; inputs: clear, step enable, direction, index bit.
  - instantiated once and reused for BUILD_A and BUILD_B.
- The top holds the FSM, latches, regA and the COMBINE logic.

Test Plan:
- MASK_W=16, mode 00, a=3, start held → o_done 4 cycles after E0, o_mask=16'hE000, o_err=0; drop start → o_mask=0 next cycle.
- MASK_W=512, mode 01, a=300 → o_done after 9 cycles, o_mask = 2^300-1 (bits 299:0 set), o_busy high for exactly 9 cycles.
- MASK_W=16, mode 10, a=4, b=9 → o_done after 9 cycles, o_mask=16'h03F0; mode 11 same bounds → 16'hFC0F; a=b=7 in mode 10 → 16'h0080.
- MASK_W=16, mode 10, a=9, b=4 → o_err=1, o_mask=16'h0000; mode 11 → o_err=1, o_mask=16'hFFFF.
- MASK_W=16, mode 00, a=5: change i_bound_a to 15 and i_mode to 01 during BUILD_A → still 16'hF800. Edge cases: a=0 → 16'h0000; right a=15 → 16'h7FFF.
- Assert i_rstn=0 mid-BUILD_B → o_busy, o_done, o_mask go 0 immediately. After release with i_start=1: new run from IDLE, mode 01 a=1 → 16'h0001.

Source files
------------

// File: rtl/mask_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mask_gen_pkg: mode codes and FSM encoding for mask_gen_param    |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
package mask_gen_pkg;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_WIN   = 2'b10;
  localparam logic [1:0] MODE_NWIN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUILD_A = 3'd1,
    ST_BUILD_B = 3'd2,
    ST_COMBINE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mask_gen_param_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mask_gen_param_if: request/result handshake for mask_gen_param  |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
interface mask_gen_param_if #(
  parameter int MASK_W = 512
);
  localparam int IDX_W = $clog2(MASK_W);

  logic              i_start;
  logic [1:0]        i_mode;
  logic [IDX_W-1:0]  i_bound_a;
  logic [IDX_W-1:0]  i_bound_b;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [MASK_W-1:0] o_mask;

  modport master (
    output i_start, i_mode, i_bound_a, i_bound_b,
    input  o_busy, o_done, o_err, o_mask
  );

  modport slave (
    input  i_start, i_mode, i_bound_a, i_bound_b,
    output o_busy, o_done, o_err, o_mask
  );
endinterface
`default_nettype wire

// File: rtl/mask_fill_engine.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mask_fill_engine: binary-weighted run accumulator, MSB first    |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module mask_fill_engine #(
  parameter int MASK_W = 512,
  parameter int IDX_W  = $clog2(MASK_W)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic              i_left,
  input  logic              i_bit,
  output logic [MASK_W-1:0] o_acc,
  output logic [MASK_W-1:0] o_acc_nxt,
  output logic [IDX_W-1:0]  o_cnt,
  output logic              o_last
);
  localparam logic [IDX_W-1:0] c_cnt_init = IDX_W'(IDX_W - 1);

  logic [MASK_W-1:0] r_acc;
  logic [IDX_W-1:0]  r_cnt;
  logic [IDX_W:0]    w_len;
  logic [MASK_W-1:0] w_shifted;

  // 2^s never exceeds MASK_W/2, so the shift always keeps part of the old contents
  assign w_len     = (IDX_W + 1)'(1) << r_cnt;
  assign w_shifted = i_left ? ((r_acc >> w_len) | ~({MASK_W{1'b1}} >> w_len))
                            : ((r_acc << w_len) | ~({MASK_W{1'b1}} << w_len));

  assign o_acc_nxt = (i_step && i_bit) ? w_shifted : r_acc;
  assign o_acc     = r_acc;
  assign o_cnt     = r_cnt;
  assign o_last    = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= c_cnt_init;
    end else if (i_step) begin
      r_acc <= o_acc_nxt;
      r_cnt <= (r_cnt == '0) ? c_cnt_init : r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mask_gen_param.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mask_gen_param: multi-cycle fill/window mask generator          |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module mask_gen_param
  import mask_gen_pkg::*;
#(
  parameter int MASK_W = 512
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  mask_gen_param_if.slave  bus
);
  localparam int IDX_W = $clog2(MASK_W);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_mode;
  logic [IDX_W-1:0]  r_bound_a;
  logic [IDX_W-1:0]  r_bound_b;
  logic              r_err;
  logic [MASK_W-1:0] r_rega;
  logic [MASK_W-1:0] r_mask;

  logic              w_clear;
  logic              w_step;
  logic              w_left;
  logic              w_bit;
  logic [MASK_W-1:0] w_acc;
  logic [MASK_W-1:0] w_acc_nxt;
  logic [IDX_W-1:0]  w_cnt;
  logic              w_last;
  logic [MASK_W-1:0] w_win;

  mask_fill_engine #(
    .MASK_W (MASK_W),
    .IDX_W  (IDX_W)
  ) u_engine (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clear   (w_clear),
    .i_step    (w_step),
    .i_left    (w_left),
    .i_bit     (w_bit),
    .o_acc     (w_acc),
    .o_acc_nxt (w_acc_nxt),
    .o_cnt     (w_cnt),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_step      = 1'b0;
    w_left      = 1'b0;
    w_bit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (bus.i_start) w_state_nxt = ST_BUILD_A;
      end
      ST_BUILD_A: begin
        w_step = 1'b1;
        w_left = (r_mode == MODE_LEFT);
        w_bit  = r_bound_a[w_cnt];
        if (w_last) begin
          // window modes restart the engine for the high bound right away
          w_clear     = r_mode[1];
          w_state_nxt = r_mode[1] ? ST_BUILD_B : ST_DONE;
        end
      end
      ST_BUILD_B: begin
        w_step = 1'b1;
        w_bit  = r_bound_b[w_cnt];
        if (w_last) w_state_nxt = ST_COMBINE;
      end
      ST_COMBINE: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (!bus.i_start) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // bits lo..hi inclusive: right-fill of hi+1 with the right-fill of lo removed
  assign w_win = r_err ? '0 : (((w_acc << 1) | {{(MASK_W-1){1'b0}}, 1'b1}) & ~r_rega);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mode    <= '0;
      r_bound_a <= '0;
      r_bound_b <= '0;
      r_err     <= 1'b0;
      r_rega    <= '0;
      r_mask    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_mode    <= bus.i_mode;
            r_bound_a <= bus.i_bound_a;
            r_bound_b <= bus.i_bound_b;
            r_err     <= bus.i_mode[1] && (bus.i_bound_a > bus.i_bound_b);
            r_rega    <= '0;
            r_mask    <= '0;
          end
        end
        ST_BUILD_A: begin
          if (w_last) begin
            if (r_mode[1]) r_rega <= w_acc_nxt;
            else           r_mask <= w_acc_nxt;
          end
        end
        ST_BUILD_B: ;
        ST_COMBINE: r_mask <= (r_mode == MODE_NWIN) ? ~w_win : w_win;
        ST_DONE: ;
        default: begin
          r_mode    <= '0;
          r_bound_a <= '0;
          r_bound_b <= '0;
          r_err     <= 1'b0;
          r_rega    <= '0;
          r_mask    <= '0;
        end
      endcase
    end
  end

  assign bus.o_busy = (r_state == ST_BUILD_A) || (r_state == ST_BUILD_B) ||
                      (r_state == ST_COMBINE);
  assign bus.o_done = (r_state == ST_DONE);
  assign bus.o_err  = (r_state == ST_DONE) && r_err;
  assign bus.o_mask = (r_state == ST_DONE) ? r_mask : '0;

endmodule
`default_nettype wire

// File: tb/tb_mask_gen_param.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_mask_gen_param: scoreboard bench for 16- and 512-bit masks   |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module tb_mask_gen_param;

  typedef struct {
    logic [511:0] mask;
    logic         err;
    int           lat;
    int           e0;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   total;
  int   bad;
  exp_t q16[$];
  exp_t q512[$];
  logic prev16;
  logic prev512;

  mask_gen_param_if #(.MASK_W(16))  bus16 ();
  mask_gen_param_if #(.MASK_W(512)) bus512 ();

  mask_gen_param #(.MASK_W(16)) u_dut16 (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus16)
  );

  mask_gen_param #(.MASK_W(512)) u_dut512 (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus512)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // monitors: compare each completed result against the oldest queued expectation
  initial begin
    prev16  = 1'b0;
    prev512 = 1'b0;
    forever begin
      @(negedge clk);
      if (bus16.o_done && !prev16) begin
        if (q16.size() == 0) chk("unexpected_done16", 1, 0);
        else begin
          exp_t x;
          x = q16.pop_front();
          chk("mask16", {496'b0, bus16.o_mask}, x.mask);
          chk("err16", bus16.o_err, x.err);
          chk("lat16", cyc - x.e0, x.lat);
        end
      end
      if (bus512.o_done && !prev512) begin
        if (q512.size() == 0) chk("unexpected_done512", 1, 0);
        else begin
          exp_t x;
          x = q512.pop_front();
          chk("mask512", bus512.o_mask, x.mask);
          chk("err512", bus512.o_err, x.err);
          chk("lat512", cyc - x.e0, x.lat);
        end
      end
      prev16  = bus16.o_done;
      prev512 = bus512.o_done;
    end
  end

  task automatic drive(input bit big, input logic [1:0] mode, input int a, input int b,
                       input logic [511:0] m, input logic e, input int lat);
    exp_t x;
    x.mask = m;
    x.err  = e;
    x.lat  = lat;
    x.e0   = cyc + 1;
    if (big) begin
      bus512.i_mode    = mode;
      bus512.i_bound_a = 9'(a);
      bus512.i_bound_b = 9'(b);
      bus512.i_start   = 1'b1;
      q512.push_back(x);
    end else begin
      bus16.i_mode    = mode;
      bus16.i_bound_a = 4'(a);
      bus16.i_bound_b = 4'(b);
      bus16.i_start   = 1'b1;
      q16.push_back(x);
    end
  endtask

  task automatic finish_run(input bit big, input logic [511:0] m, input int lat, input bit perturb);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (perturb && i == 0) begin
        bus16.i_bound_a = 4'd15;
        bus16.i_mode    = 2'b01;
      end
      if (big ? bus512.o_done : bus16.o_done) begin
        seen = 1'b1;
        break;
      end
      if (big ? bus512.o_busy : bus16.o_busy) busy_n++;
    end
    chk("done_seen", seen, 1);
    chk("busy_cycles", busy_n, lat);
    repeat (2) @(posedge clk);
    #1;
    chk("mask_held", big ? bus512.o_mask : {496'b0, bus16.o_mask}, m);
    if (big) bus512.i_start = 1'b0;
    else     bus16.i_start  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mask_after_drop", big ? bus512.o_mask : {496'b0, bus16.o_mask}, 0);
    chk("done_after_drop", big ? bus512.o_done : bus16.o_done, 0);
  endtask

  task automatic run(input bit big, input logic [1:0] mode, input int a, input int b,
                     input logic [511:0] m, input logic e, input int lat, input bit perturb);
    @(posedge clk); #1;
    drive(big, mode, a, b, m, e, lat);
    finish_run(big, m, lat, perturb);
  endtask

  initial begin
    logic [511:0] m300;
    logic [511:0] m511;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus16.i_start  = 1'b0; bus16.i_mode  = '0; bus16.i_bound_a  = '0; bus16.i_bound_b  = '0;
    bus512.i_start = 1'b0; bus512.i_mode = '0; bus512.i_bound_a = '0; bus512.i_bound_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy16", bus16.o_busy, 0);
    chk("rst_done16", bus16.o_done, 0);
    chk("rst_err16", bus16.o_err, 0);
    chk("rst_mask16", bus16.o_mask, 0);
    chk("rst_mask512", bus512.o_mask, 0);
    rstn = 1'b1;

    run(0, 2'b00, 3, 0, 512'hE000, 0, 4, 0);
    run(0, 2'b10, 4, 9, 512'h03F0, 0, 9, 0);
    run(0, 2'b11, 4, 9, 512'hFC0F, 0, 9, 0);
    run(0, 2'b10, 7, 7, 512'h0080, 0, 9, 0);
    run(0, 2'b10, 9, 4, 512'h0000, 1, 9, 0);
    run(0, 2'b11, 9, 4, 512'hFFFF, 1, 9, 0);
    run(0, 2'b00, 5, 0, 512'hF800, 0, 4, 1);
    run(0, 2'b00, 0, 0, 512'h0000, 0, 4, 0);
    run(0, 2'b01, 15, 0, 512'h7FFF, 0, 4, 0);
    run(0, 2'b00, 15, 3, 512'hFFFE, 0, 4, 0);
    run(0, 2'b11, 0, 15, 512'h0000, 0, 9, 0);

    m300 = (512'd1 << 300) - 512'd1;
    run(1, 2'b01, 300, 0, m300, 0, 9, 0);
    m511 = ~512'd1;
    run(1, 2'b00, 511, 0, m511, 0, 9, 0);

    // reset in the middle of the high-bound build, then restart with start held
    @(posedge clk); #1;
    bus16.i_mode = 2'b10; bus16.i_bound_a = 4'd4; bus16.i_bound_b = 4'd9; bus16.i_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_in_build_b", bus16.o_busy, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_busy", bus16.o_busy, 0);
    chk("midrst_done", bus16.o_done, 0);
    chk("midrst_mask", bus16.o_mask, 0);
    drive(0, 2'b01, 1, 0, 512'h0001, 0, 4);
    #1;
    rstn = 1'b1;
    finish_run(0, 512'h0001, 4, 0);

    repeat (3) @(posedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q512_drained", q512.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
